// File: rtl/warp_ctl_arb.sv
// warp_ctl_arb: per-input FIFOs merged by a round-robin arbiter into one registered
// valid/ready channel, with per-warp in-flight counters exposed as pending_mask.
module warp_ctl_arb #(
  parameter int NUM_INPUTS     = 4,
  parameter int WARP_CNT_WIDTH = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_INPUTS-1:0]                in_valid,
  input  logic [NUM_INPUTS*WARP_CNT_WIDTH-1:0] in_wid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]     in_data,
  output logic [NUM_INPUTS-1:0]                in_ready,
  output logic                                 out_valid,
  output logic [WARP_CNT_WIDTH-1:0]            out_wid,
  output logic [DATA_WIDTH-1:0]                out_data,
  input  logic                                 out_ready,
  output logic [2**WARP_CNT_WIDTH-1:0]         pending_mask
);
  localparam int NW  = 2**WARP_CNT_WIDTH;
  localparam int EW  = WARP_CNT_WIDTH + DATA_WIDTH;
  localparam int PW  = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int RW  = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  localparam int CW  = $clog2(NUM_INPUTS*FIFO_DEPTH + 2);

  logic [EW-1:0]         mem [NUM_INPUTS][FIFO_DEPTH];
  logic [PW-1:0]         rd [NUM_INPUTS];
  logic [PW-1:0]         wr [NUM_INPUTS];
  logic [FCW-1:0]        fcnt [NUM_INPUTS];
  logic [CW-1:0]         cnt [NW];
  logic [CW-1:0]         cnt_nxt [NW];
  logic [RW-1:0]         rr;
  logic [RW-1:0]         grant;
  logic [NUM_INPUTS-1:0] push, pop, nonempty;
  logic                  found, load_en, hs;

  assign load_en = !out_valid || out_ready;
  assign hs      = out_valid && out_ready && !reset;
  assign push    = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      nonempty[i] = fcnt[i] != '0;
      in_ready[i] = fcnt[i] != FCW'(FIFO_DEPTH) && !reset;
    end
  end

  // first non-empty FIFO at or after the pointer, wrapping
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = int'(rr) + k;
      idx = idx >= NUM_INPUTS ? idx - NUM_INPUTS : idx;
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = RW'(idx);
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++)
      pop[i] = load_en && found && grant == RW'(i) && !reset;
  end

  always_comb begin
    for (int w = 0; w < NW; w++) begin
      cnt_nxt[w] = cnt[w] - CW'(hs && out_wid == WARP_CNT_WIDTH'(w));
      for (int i = 0; i < NUM_INPUTS; i++)
        cnt_nxt[w] = cnt_nxt[w] + CW'(push[i] && in_wid[i*WARP_CNT_WIDTH +: WARP_CNT_WIDTH] == WARP_CNT_WIDTH'(w));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_wid      <= '0;
      out_data     <= '0;
      rr           <= '0;
      pending_mask <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        rd[i]   <= '0;
        wr[i]   <= '0;
        fcnt[i] <= '0;
      end
      for (int w = 0; w < NW; w++) cnt[w] <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (push[i]) begin
          mem[i][wr[i]] <= {in_wid[i*WARP_CNT_WIDTH +: WARP_CNT_WIDTH], in_data[i*DATA_WIDTH +: DATA_WIDTH]};
          wr[i]         <= wr[i] == PW'(FIFO_DEPTH-1) ? '0 : wr[i] + 1'b1;
        end
        if (pop[i]) rd[i] <= rd[i] == PW'(FIFO_DEPTH-1) ? '0 : rd[i] + 1'b1;
        fcnt[i] <= fcnt[i] + FCW'(push[i]) - FCW'(pop[i]);
      end
      if (load_en) begin
        out_valid <= found;
        if (found) begin
          {out_wid, out_data} <= mem[grant][rd[grant]];
          rr                  <= grant == RW'(NUM_INPUTS-1) ? '0 : grant + 1'b1;
        end
      end
      for (int w = 0; w < NW; w++) begin
        cnt[w]          <= cnt_nxt[w];
        pending_mask[w] <= cnt_nxt[w] != '0;
      end
    end
  end

`ifndef SYNTHESIS
  logic                      stall_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [WARP_CNT_WIDTH-1:0] wid_q;

  always_ff @(posedge clk) begin
    stall_q <= !reset && out_valid && !out_ready;
    data_q  <= out_data;
    wid_q   <= out_wid;
    if (!reset) begin
      for (int i = 0; i < NUM_INPUTS; i++)
        assert (!(push[i] && fcnt[i] == FCW'(FIFO_DEPTH)));
      for (int w = 0; w < NW; w++) begin
        assert (!(hs && out_wid == WARP_CNT_WIDTH'(w) && cnt[w] == '0));
        assert (cnt_nxt[w] <= CW'(NUM_INPUTS*FIFO_DEPTH + 1));
      end
      if (stall_q) assert (out_data == data_q && out_wid == wid_q);
    end
  end
`endif
endmodule

// File: tb/tb_warp_ctl_arb.sv
// tb_warp_ctl_arb: directed scenarios on a 4-input instance plus a randomized
// scoreboard run on a 1-input/depth-1 instance.
module tb_warp_ctl_arb;
  localparam int N = 4, WW = 4, DW = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    in_valid = '0;
  logic [N*WW-1:0] in_wid = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [WW-1:0]   out_wid;
  logic [DW-1:0]   out_data;
  logic            out_ready = 1'b0;
  logic [15:0]     pending_mask;

  logic        s_valid = 1'b0;
  logic [3:0]  s_wid = '0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic        s_ovalid;
  logic [3:0]  s_owid;
  logic [15:0] s_odata;
  logic        s_oready = 1'b0;
  logic [15:0] s_pmask;

  warp_ctl_arb #(.NUM_INPUTS(N), .WARP_CNT_WIDTH(WW), .DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wid(in_wid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_wid(out_wid), .out_data(out_data),
    .out_ready(out_ready), .pending_mask(pending_mask)
  );

  warp_ctl_arb #(.NUM_INPUTS(1), .WARP_CNT_WIDTH(4), .DATA_WIDTH(16), .FIFO_DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_wid(s_wid), .in_data(s_data),
    .in_ready(s_ready), .out_valid(s_ovalid), .out_wid(s_owid), .out_data(s_odata),
    .out_ready(s_oready), .pending_mask(s_pmask)
  );

  int errors = 0;
  int checks = 0;
  logic [WW+DW-1:0] exp_q[$];
  logic [19:0]      sq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic [WW-1:0] w, input logic [DW-1:0] d);
    in_wid[i*WW +: WW]  = w;
    in_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    #1;
  endtask

  // every handshake on the main instance must match the next expected packet
  always @(negedge clk) begin
    logic [WW+DW-1:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        check("out_wid", 64'(out_wid), 64'(e[WW+DW-1:DW]));
        check("out_data", out_data, e[DW-1:0]);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[N];
    int n;
    logic [N-1:0] acc;
    int mc[16];
    logic [15:0] em;
    logic [19:0] se;
    logic sacc, shs;

    tick;
    tick;
    check("rst_in_ready_low", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'hf);
    check("rst_pmask", 64'(pending_mask), 64'd0);
    check("rst_out_wid", 64'(out_wid), 64'd0);
    check("rst_out_data", out_data, 64'd0);

    // single packet through input 2
    out_ready = 1'b1;
    set_in(2, 4'd5, 64'hABCD);
    in_valid = 4'b0100;
    exp_q.push_back({4'd5, 64'hABCD});
    tick;
    in_valid = '0;
    check("sp_pmask_e0", 64'(pending_mask), 64'h20);
    check("sp_ovalid_e0", 64'(out_valid), 64'd0);
    tick;
    check("sp_ovalid_e1", 64'(out_valid), 64'd1);
    check("sp_wid_e1", 64'(out_wid), 64'd5);
    check("sp_data_e1", out_data, 64'hABCD);
    check("sp_pmask_e1", 64'(pending_mask), 64'h20);
    tick;
    check("sp_ovalid_e2", 64'(out_valid), 64'd0);
    check("sp_pmask_e2", 64'(pending_mask), 64'd0);

    // fairness: 4 packets per input, all continuously valid
    do_reset;
    for (int k = 0; k < 16; k++)
      exp_q.push_back({WW'(k % 4), 64'((k % 4) * 256 + k / 4)});
    for (int i = 0; i < N; i++) seq[i] = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i] = seq[i] < 4;
        set_in(i, WW'(i), 64'(i * 256 + seq[i]));
      end
      acc = in_valid & in_ready;
      tick;
      for (int i = 0; i < N; i++) seq[i] += int'(acc[i]);
      if (c >= 1 && c <= 16) check("fair_throughput", 64'(out_valid), 64'd1);
    end
    in_valid = '0;
    check("fair_drained", 64'(exp_q.size()), 64'd0);
    check("fair_idle", 64'(out_valid), 64'd0);

    // backpressure on input 0
    do_reset;
    in_valid = 4'b0001;
    n = 0;
    for (int c = 0; c < 10 && in_ready[0]; c++) begin
      set_in(0, 4'd3, 64'h100 + 64'(n));
      exp_q.push_back({4'd3, 64'h100 + 64'(n)});
      tick;
      n++;
    end
    in_valid = '0;
    check("bp_accepted", 64'(n), 64'd3);
    check("bp_in_ready", 64'(in_ready), 64'he);
    for (int c = 0; c < 4; c++) begin
      check("bp_stall_valid", 64'(out_valid), 64'd1);
      check("bp_stall_data", out_data, 64'h100);
      tick;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick;
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // same-warp collision on wid 7
    do_reset;
    set_in(0, 4'd7, 64'h70);
    set_in(1, 4'd7, 64'h71);
    set_in(2, 4'd7, 64'h72);
    set_in(3, 4'd7, 64'h73);
    for (int i = 0; i < N; i++) exp_q.push_back({4'd7, 64'h70 + 64'(i)});
    in_valid = 4'b1011;
    tick;
    in_valid = '0;
    check("coll_cnt3", 64'(dut.cnt[7]), 64'd3);
    check("coll_pmask", 64'(pending_mask), 64'h80);
    tick;
    check("coll_first_out", out_data, 64'h70);
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    tick;
    in_valid = '0;
    check("coll_pushpop_cnt", 64'(dut.cnt[7]), 64'd3);
    tick;
    check("coll_pmask_2left", 64'(pending_mask), 64'h80);
    tick;
    check("coll_pmask_1left", 64'(pending_mask), 64'h80);
    tick;
    check("coll_pmask_clear", 64'(pending_mask), 64'd0);
    check("coll_drained", 64'(exp_q.size()), 64'd0);

    // reset mid-flight with 5 buffered packets
    do_reset;
    for (int i = 0; i < N; i++) set_in(i, WW'(i + 1), 64'h200 + 64'(i));
    in_valid = 4'hf;
    tick;
    set_in(0, 4'd9, 64'h299);
    in_valid = 4'b0001;
    tick;
    in_valid = '0;
    check("rmf_loaded", 64'(pending_mask), 64'h21e);
    reset = 1'b1;
    #1;
    check("rmf_ready_in_reset", 64'(in_ready), 64'd0);
    tick;
    check("rmf_ovalid", 64'(out_valid), 64'd0);
    check("rmf_pmask", 64'(pending_mask), 64'd0);
    reset = 1'b0;
    #1;
    check("rmf_ready_after", 64'(in_ready), 64'hf);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      check("rmf_no_stale", 64'(out_valid), 64'd0);
    end
    set_in(1, 4'd2, 64'h3333);
    in_valid = 4'b0010;
    exp_q.push_back({4'd2, 64'h3333});
    tick;
    in_valid = '0;
    tick;
    check("rmf_fresh", out_data, 64'h3333);
    tick;
    check("rmf_drained", 64'(exp_q.size()), 64'd0);

    // degenerate instance: random traffic against a queue and per-warp model
    do_reset;
    for (int w = 0; w < 16; w++) mc[w] = 0;
    for (int c = 0; c < 10020; c++) begin
      s_valid  = c < 10000 ? 1'($urandom_range(0, 1)) : 1'b0;
      s_oready = c < 10000 ? 1'($urandom_range(0, 1)) : 1'b1;
      s_wid    = 4'($urandom);
      s_data   = 16'($urandom);
      shs  = s_ovalid && s_oready;
      sacc = s_valid && s_ready;
      if (shs) begin
        if (sq.size() == 0) check("deg_unexpected", 64'(sq.size()), 64'd1);
        else begin
          se = sq.pop_front();
          check("deg_wid", 64'(s_owid), 64'(se[19:16]));
          check("deg_data", 64'(s_odata), 64'(se[15:0]));
          mc[se[19:16]]--;
        end
      end
      if (sacc) begin
        sq.push_back({s_wid, s_data});
        mc[s_wid]++;
      end
      tick;
      for (int w = 0; w < 16; w++) em[w] = mc[w] != 0;
      check("deg_pmask", 64'(s_pmask), 64'(em));
    end
    check("deg_no_loss", 64'(sq.size()), 64'd0);
    check("deg_idle", 64'(s_ovalid), 64'd0);

    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/warp_ctl_arb.md
Name: warp_ctl_arb

Overview:
Parametrised multi-source warp-control merger. It collects warp-control packets (wid plus packed tmc/wspawn/split/join/barrier payload) from NUM_INPUTS issue-side producers, for example SFU/CSR slices. Each producer gets its own FIFO, and a round-robin arbiter drains them into one registered valid/ready channel feeding the warp scheduler. Unlike the point-to-point warp-control bus, this block adds backpressure, buffering, fair arbitration and a per-warp pending mask, so the scheduler can hold warps that have control updates in flight.

Parameters:
NUM_INPUTS, 4, number of producer channels (>=1)
WARP_CNT_WIDTH, 4, width of wid; NUM_WARPS = 2**WARP_CNT_WIDTH
DATA_WIDTH, 64, width of packed control payload (opaque to this block)
FIFO_DEPTH, 2, entries per input FIFO (>=1, any integer)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  NUM_INPUTS  per-input packet valid
in_wid  in  NUM_INPUTS*WARP_CNT_WIDTH  per-input warp id, input i at slice i
in_data  in  NUM_INPUTS*DATA_WIDTH  per-input payload
in_ready  out  NUM_INPUTS  per-input FIFO not full
out_valid  out  1  merged packet valid (registered)
out_wid  out  WARP_CNT_WIDTH  merged warp id (registered)
out_data  out  DATA_WIDTH  merged payload (registered)
out_ready  in  1  scheduler accepts packet
pending_mask  out  NUM_WARPS  bit w set while any packet for warp w is buffered or held at the output

Behaviour:
- All state updates on the rising edge of clk; reset is synchronous, active-high, one clk is sufficient.
- Reset values:
  - all FIFOs empty, out_valid=0, out_wid=0, out_data=0
  - round-robin pointer=0, all per-warp counters=0, pending_mask=0
  - in_ready=0 while reset is high; no enqueue and no dequeue during reset.
- Reset mid-operation discards all buffered packets. No output handshake occurs in the reset cycle.
- Enqueue: input i pushes {in_wid_i, in_data_i} when in_valid[i] && in_ready[i]. in_ready[i] = !full_i && !reset, and is combinational from FIFO state only, never from in_valid.
- Output register loads when !out_valid || out_ready (load_en).
- Arbitration, combinational, one grant per cycle:
  - Candidates are the non-empty FIFOs.
  - Search starts at the pointer and wraps modulo NUM_INPUTS; the first non-empty FIFO wins.
  - On load_en with a winner g: pop FIFO g, load its head into the output register, set pointer=(g+1) mod NUM_INPUTS.
  - With no winner and load_en asserted, out_valid<=0.
  - The pointer is unchanged when there is no grant.
- Latency: a packet accepted at edge E into an empty system drives out_valid=1 from edge E+1. There is no FIFO bypass.
- Throughput: 1 packet/cycle while out_ready=1. A full FIFO accepts a push in the same cycle it is popped only if it was not full at the start of the cycle; in_ready does not look ahead.
- Stall: while out_valid && !out_ready, out_wid and out_data hold stable and no FIFO pops.
- Ordering: FIFO order is preserved per input. No ordering is guaranteed across inputs.
- Pending counters:
  - One counter per warp, width clog2(NUM_INPUTS*FIFO_DEPTH+2).
  - Each cycle: +(number of inputs enqueuing wid w), -1 if out_valid && out_ready && out_wid==w.
  - Simultaneous increment and decrement on the same warp apply the net value.
  - pending_mask[w] = (count[w]!=0), registered with the counter.
- Assertions (sim only): counter never underflows or overflows; no push to a full FIFO; out_data stable under stall.

Test Plan:
- Single packet: NUM_INPUTS=4; input 2 sends wid=5, data=0xABCD at edge 0 with out_ready=1. Expect out_valid=1 with wid=5 and data=0xABCD after edge 1, and pending_mask[5]=1 after edges 0 and 1. After the edge-2 handshake expect out_valid=0 and pending_mask=0.
- Fairness: all 4 inputs continuously valid, FIFO_DEPTH=2, out_ready=1. Expect output source order 0,1,2,3,0,1,… with exactly 1 packet/cycle and no input starved for more than 4 cycles.
- Backpressure:
  - Hold out_ready=0 and drive input 0 continuously.
  - Expect in_ready[0] to drop after FIFO_DEPTH accepted pushes plus the one output-register load (3 packets for depth 2).
  - out_data stays constant throughout the stall.
  - Release out_ready; expect packets in push order.
- Same-warp collision: inputs 0,1,3 all enqueue wid=7 in the same cycle. Expect count[7]=3 and pending_mask[7]=1, which clears only after the third output handshake with wid=7. Also check a cycle with a simultaneous push and pop of wid=7 leaves the count unchanged.
- Reset mid-flight: load 5 packets with out_ready=0, then assert reset for 1 cycle. Expect out_valid=0, pending_mask=0, in_ready=0 during reset and all 1 after it. No stale packet ever appears at the output.
- Degenerate config: NUM_INPUTS=1, FIFO_DEPTH=1, random in_valid/out_ready for 10k cycles. A scoreboard checks order, zero loss and zero duplication, and the pending_mask reference model matches.
